// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage with a first-word fall-through prefetch FIFO between the instruction cache and decode.
// Optional fetch-stall counter on o_stall_count is built when PREFETCH_STATS_EN is defined.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic [31:0] o_address1,
    input  logic [31:0] i_data1,
    input  logic        i_hit1,
    input  logic        i_abort1,
    input  logic        i_clear,
    input  logic [31:0] i_pc_new,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_abort,
    output logic [15:0] o_stall_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        FETCH      = 1'b0,
        ABORT_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic        abort;
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    entry_t        mem_q [DEPTH];

    logic   pop;
    logic   push;
    logic   full;
    entry_t head;

    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = o_valid & i_ready;
        push = (state_q == FETCH) & i_hit1 & (~full | pop) & ~i_clear;
    end

    // Redirect outranks everything: flush, drop any pop, restart fetch at the word-aligned target.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC & ~32'h3;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (i_clear) begin
            state_q  <= FETCH;
            pc_q     <= i_pc_new & ~32'h3;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            count_q <= count_q + CW'(push) - CW'(pop);
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                pc_q     <= pc_q + 32'd4;
                if (i_abort1)
                    state_q <= ABORT_HOLD;
            end
        end
    end

    // NOTE: storage has no reset; count_q alone decides validity and empty outputs are masked.
    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= '{abort: i_abort1, pc: pc_q, data: i_data1};
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        o_valid       = (count_q != '0);
        o_instruction = o_valid ? head.data  : 32'h0;
        o_pc          = o_valid ? head.pc    : 32'h0;
        o_abort       = o_valid & head.abort;
        o_address1    = pc_q;
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stall_q;

    // Counts fetch cycles that wanted to push but could not; survives redirects.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            stall_q <= '0;
        else if ((state_q == FETCH) && !i_clear && !push && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign o_stall_count = stall_q;
`else
    assign o_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: fill, streaming, misses, abort hold, redirects,
// PC wrap and asynchronous reset, using a second instance with a high RESET_PC.
module tb_fetch_prefetch_buffer;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] address1;
    logic [31:0] data1;
    logic        hit1;
    logic        abort1;
    logic        clear;
    logic [31:0] pc_new;
    logic        valid;
    logic        ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        abort;
    logic [15:0] stall_count;

    logic        rst2_n;
    logic [31:0] address2;
    logic [31:0] data2;
    logic        hit2;
    logic        ready2;
    logic        valid2;
    logic [31:0] instruction2;
    logic [31:0] pc2;
    logic        abort2;
    logic [15:0] stall_count2;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] stall_base;

    // Cache model: word content is a fixed function of the address.
    assign data1 = address1 ^ KEY;
    assign data2 = address2 ^ KEY;

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .o_address1(address1), .i_data1(data1),
        .i_hit1(hit1), .i_abort1(abort1), .i_clear(clear), .i_pc_new(pc_new),
        .o_valid(valid), .i_ready(ready), .o_instruction(instruction), .o_pc(pc),
        .o_abort(abort), .o_stall_count(stall_count)
    );

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .i_clk(clk), .i_reset_n(rst2_n), .o_address1(address2), .i_data1(data2),
        .i_hit1(hit2), .i_abort1(1'b0), .i_clear(1'b0), .i_pc_new(32'h0),
        .o_valid(valid2), .i_ready(ready2), .o_instruction(instruction2), .o_pc(pc2),
        .o_abort(abort2), .o_stall_count(stall_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle well after the edge before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        hit1   = 1'b0;
        abort1 = 1'b0;
        clear  = 1'b0;
        pc_new = 32'h0;
        ready  = 1'b0;
        hit2   = 1'b0;
        ready2 = 1'b0;
        #12;

        // Reset state
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_addr", address1, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_abort", 32'(abort), 32'h0);
        check("rst_stall", 32'(stall_count), 32'h0);
        check("rst2_addr", address2, 32'hFFFF_FFF8);

        // Fill: 0,4,8,12 pushed, then full holds PC at 16
        rst_n = 1'b1;
        hit1  = 1'b1;
        #1;
        check("fill_novis", 32'(valid), 32'h0);
        tick();
        check("fill1_valid", 32'(valid), 32'h1);
        check("fill1_pc", pc, 32'h0);
        check("fill1_instr", instruction, 32'h0000_0000 ^ KEY);
        check("fill1_addr", address1, 32'h4);
        tick();
        tick();
        tick();
        check("fill4_addr", address1, 32'h10);
        tick();
        tick();
        check("full_addr_hold", address1, 32'h10);
        check("full_head_pc", pc, 32'h0);
        check("full_valid", 32'(valid), 32'h1);

        // Streaming: one pop and one push per cycle while full
        ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("stream_pc%0d", k), pc, 32'(4 * k));
            check($sformatf("stream_addr%0d", k), address1, 32'(16 + 4 * k));
        end
        check("stream_instr", instruction, 32'h10 ^ KEY);

        // Misses: PC and head hold, stall counter (if built) steps by 3
        stall_base = stall_count;
        hit1  = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        tick();
        check("miss_addr", address1, 32'h20);
        check("miss_head_pc", pc, 32'h10);
`ifdef PREFETCH_STATS_EN
        check("miss_stall_delta", 32'(stall_count - stall_base), 32'h3);
`else
        check("miss_stall_zero", 32'(stall_count), 32'h0);
`endif

        // Redirect to 0x40, then an aborted fetch there
        clear  = 1'b1;
        pc_new = 32'h40;
        hit1   = 1'b1;
        tick();
        check("redir40_valid", 32'(valid), 32'h0);
        check("redir40_addr", address1, 32'h40);
        clear  = 1'b0;
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_valid", 32'(valid), 32'h1);
        check("abort_flag", 32'(abort), 32'h1);
        check("abort_pc", pc, 32'h40);
        check("abort_instr", instruction, 32'h40 ^ KEY);
        check("abort_addr", address1, 32'h44);
        tick();
        tick();
        check("hold_addr", address1, 32'h44);
        check("hold_pc", pc, 32'h40);
        ready = 1'b1;
        tick();
        check("hold_drained", 32'(valid), 32'h0);
        check("hold_addr2", address1, 32'h44);

        // Leave ABORT_HOLD via redirect to an unaligned target
        clear  = 1'b1;
        pc_new = 32'h0000_0102;
        ready  = 1'b0;
        tick();
        check("redir100_addr", address1, 32'h100);
        check("redir100_valid", 32'(valid), 32'h0);
        clear = 1'b0;
        tick();
        check("resume_valid", 32'(valid), 32'h1);
        check("resume_pc", pc, 32'h100);
        check("resume_abort", 32'(abort), 32'h0);
        check("resume_addr", address1, 32'h104);

        // Three entries, then redirect with a simultaneous pop
        tick();
        tick();
        check("three_addr", address1, 32'h10C);
        check("three_head", pc, 32'h100);
        clear  = 1'b1;
        ready  = 1'b1;
        pc_new = 32'h200;
        tick();
        check("flush_valid", 32'(valid), 32'h0);
        check("flush_addr", address1, 32'h200);
        clear = 1'b0;
        #1;
        check("flush_novis", 32'(valid), 32'h0);
        tick();
        check("post_flush_pc", pc, 32'h200);
        check("post_flush_valid", 32'(valid), 32'h1);
        tick();
        check("post_flush_pc2", pc, 32'h204);

        // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0 then async reset
        rst2_n = 1'b1;
        hit2   = 1'b1;
        ready2 = 1'b1;
        tick();
        check("wrap_pc0", pc2, 32'hFFFF_FFF8);
        check("wrap_addr0", address2, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc1", pc2, 32'hFFFF_FFFC);
        check("wrap_addr1", address2, 32'h0);
        tick();
        check("wrap_pc2", pc2, 32'h0);
        check("wrap_instr2", instruction2, 32'h0 ^ KEY);
        check("wrap_addr2", address2, 32'h4);
        #1;
        rst2_n = 1'b0;
        #1;
        check("async_valid", 32'(valid2), 32'h0);
        check("async_pc", pc2, 32'h0);
        check("async_addr", address2, 32'hFFFF_FFF8);
        check("async_stall", 32'(stall_count2), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
